// File: rtl/twist_rx_pkg.sv
// Shared definitions for the twisted-ring (Johnson) code receiver:
// phase-width helper, FSM state encoding and modulo-2N phase increment.
package twist_rx_pkg;

   // Width of a phase index for a CNT_SIZE-bit Johnson code (2*CNT_SIZE phases).
   function automatic int ph_w(input int cnt_size);
      return (cnt_size < 1) ? 1 : $clog2(2 * cnt_size);
   endfunction

   // Sequence-tracking states.
   typedef enum logic [1:0] {
      ST_HUNT  = 2'd0,
      ST_CHECK = 2'd1,
      ST_LOCK  = 2'd2
   } state_t;

   // Successor of phase p in a ring of 'span' phases. The ring size is
   // 2*CNT_SIZE, which is generally not a power of two, so a plain binary
   // increment of a PH_W-bit value would be wrong.
   function automatic int phase_inc(input int p, input int span);
      return (p + 1 >= span) ? 0 : p + 1;
   endfunction

endpackage : twist_rx_pkg

// File: rtl/twist_phase_dec.sv
// Combinational Johnson-code decoder: maps a CNT_SIZE-bit twisted-ring
// word to {legal, phase}. Phase 0 is all zeros, phases 1..N fill from the
// MSB downward, phases N+1..2N-1 drain ones out of the MSB end so that only
// the lower 2N-p bits remain set. Any other bit pattern is illegal.
module twist_phase_dec
   import twist_rx_pkg::*;
#(
   parameter int CNT_SIZE = 8,
   parameter int PH_W     = ph_w(CNT_SIZE)
) (
   input  logic [CNT_SIZE-1:0] code,
   output logic                legal,
   output logic [PH_W-1:0]     phase
);

   // Word with the upper k bits set (k = 0 gives all zeros, k = N all ones).
   function automatic logic [CNT_SIZE-1:0] upper_mask(input int k);
      logic [CNT_SIZE-1:0] ones;
      ones = '1;
      return ~(ones >> k);
   endfunction

   // Word with the lower k bits set.
   function automatic logic [CNT_SIZE-1:0] lower_mask(input int k);
      logic [CNT_SIZE-1:0] ones;
      ones = '1;
      return ~(ones << k);
   endfunction

   // Compare the word against every legal pattern; at most one can match.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; otherwise
      // the tool infers latches to hold them when no pattern matches.
      legal = 1'b0;
      phase = '0;
      for (int k = 0; k <= CNT_SIZE; k++) begin
         if (code == upper_mask(k)) begin
            legal = 1'b1;
            phase = PH_W'(k);
         end
         if ((k >= 1) && (k <= CNT_SIZE - 1) && (code == lower_mask(k))) begin
            legal = 1'b1;
            phase = PH_W'(2 * CNT_SIZE - k);
         end
      end
   end

endmodule : twist_phase_dec

// File: rtl/twist_rx.sv
// Twisted-ring code receiver: validates and decodes each incoming word,
// tracks sequence continuity with a HUNT/CHECK/LOCK state machine, and
// reports sequence errors while locked with a saturating error counter.
// All outputs are registered; a word sampled with code_vld shows up on
// the outputs one cycle later.
module twist_rx
   import twist_rx_pkg::*;
#(
   parameter int CNT_SIZE = 8,
   parameter int PH_W     = ph_w(CNT_SIZE),
   parameter int LOCK_N   = 4,
   parameter int MISS_N   = 2,
   parameter int ERR_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CNT_SIZE-1:0] code_in,
   input  logic                code_vld,
   output logic [PH_W-1:0]     phase,
   output logic                phase_vld,
   output logic                locked,
   output logic                err,
   output logic [ERR_W-1:0]    err_cnt
);

   // Counters only need to reach LOCK_N / MISS_N before the state changes.
   localparam int MC_W = $clog2(LOCK_N + 1);
   localparam int MS_W = $clog2(MISS_N + 1);
   localparam int SPAN = 2 * CNT_SIZE;

   state_t            state;
   logic [PH_W-1:0]   exp_ph;
   logic [MC_W-1:0]   match_cnt;
   logic [MS_W-1:0]   miss_cnt;

   logic              dec_legal;
   logic [PH_W-1:0]   dec_phase;

   // Successor of a phase within the 2N-phase ring.
   function automatic logic [PH_W-1:0] next_ph(input logic [PH_W-1:0] p);
      return PH_W'(phase_inc(int'(p), SPAN));
   endfunction

   twist_phase_dec #(
      .CNT_SIZE (CNT_SIZE),
      .PH_W     (PH_W)
   ) u_dec (
      .code  (code_in),
      .legal (dec_legal),
      .phase (dec_phase)
   );

   // Sequence FSM, counters and registered outputs in one clocked process.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and active-low: it is only looked at on a
      // clock edge, and it takes priority over any word presented that cycle.
      if (!rst) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         state     <= ST_HUNT;
         exp_ph    <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         phase     <= '0;
         phase_vld <= 1'b0;
         locked    <= 1'b0;
         err       <= 1'b0;
         err_cnt   <= '0;
      end else begin
         // Pulses default low; they are raised below only for a valid word.
         phase_vld <= 1'b0;
         err       <= 1'b0;

         if (code_vld) begin
            // Any legal word refreshes the phase output, whatever the state.
            if (dec_legal) begin
               phase     <= dec_phase;
               phase_vld <= 1'b1;
            end

            unique case (state)
               ST_HUNT: begin
                  if (dec_legal) begin
                     exp_ph    <= next_ph(dec_phase);
                     match_cnt <= MC_W'(1);
                     if (LOCK_N <= 1) begin
                        state    <= ST_LOCK;
                        locked   <= 1'b1;
                        miss_cnt <= '0;
                     end else begin
                        state <= ST_CHECK;
                     end
                  end
               end

               ST_CHECK: begin
                  if (!dec_legal) begin
                     state     <= ST_HUNT;
                     match_cnt <= '0;
                  end else if (dec_phase == exp_ph) begin
                     match_cnt <= match_cnt + MC_W'(1);
                     exp_ph    <= next_ph(exp_ph);
                     if (int'(match_cnt) + 1 >= LOCK_N) begin
                        state    <= ST_LOCK;
                        locked   <= 1'b1;
                        miss_cnt <= '0;
                     end
                  end else begin
                     // Legal but out of order: this word starts a new run.
                     match_cnt <= MC_W'(1);
                     exp_ph    <= next_ph(dec_phase);
                  end
               end

               ST_LOCK: begin
                  // Flywheel: the expected phase advances on every valid word,
                  // so one corrupted word does not knock us out of step.
                  exp_ph <= next_ph(exp_ph);
                  if (dec_legal && (dec_phase == exp_ph)) begin
                     miss_cnt <= '0;
                  end else begin
                     err <= 1'b1;
                     if (err_cnt != '1) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                     end
                     miss_cnt <= miss_cnt + MS_W'(1);
                     if (int'(miss_cnt) + 1 >= MISS_N) begin
                        state     <= ST_HUNT;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                     end
                  end
               end

               default: begin
                  state  <= ST_HUNT;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule : twist_rx

// File: tb/tb_twist_rx.sv
// Self-checking bench for twist_rx. Two instances see the same stimulus:
// one with the default 16-bit error counter and one with a 2-bit counter
// to exercise saturation. A behavioural model of the phase mapping and the
// lock rules predicts every output each cycle; directed checks pin the
// scenarios with hand-computed values.
module tb_twist_rx;

   localparam int N    = 8;
   localparam int SPAN = 2 * N;

   logic       clk;
   logic       rst;
   logic [7:0] code_in;
   logic       code_vld;

   logic [3:0]  phase_a, phase_b;
   logic        pvld_a, pvld_b, locked_a, locked_b, err_a, err_b;
   logic [15:0] err_cnt_a;
   logic [1:0]  err_cnt_b;

   int n_checks = 0;
   int n_pass   = 0;
   int tx_p     = 0;

   // Model state.
   bit model_live = 0;
   int m_mode = 0;  // 0 hunt, 1 check, 2 lock
   int m_exp = 0, m_match = 0, m_miss = 0;
   int m_phase = 0, m_pvld = 0, m_locked = 0, m_err = 0;
   int m_cnt_a = 0, m_cnt_b = 0;

   twist_rx #(.CNT_SIZE(N), .LOCK_N(4), .MISS_N(2), .ERR_W(16)) dut_a (
      .clk(clk), .rst(rst), .code_in(code_in), .code_vld(code_vld),
      .phase(phase_a), .phase_vld(pvld_a), .locked(locked_a),
      .err(err_a), .err_cnt(err_cnt_a)
   );

   twist_rx #(.CNT_SIZE(N), .LOCK_N(4), .MISS_N(2), .ERR_W(2)) dut_b (
      .clk(clk), .rst(rst), .code_in(code_in), .code_vld(code_vld),
      .phase(phase_b), .phase_vld(pvld_b), .locked(locked_b),
      .err(err_b), .err_cnt(err_cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
   endtask

   // Code word for phase p, straight from the phase mapping.
   function automatic logic [7:0] code_of(input int p);
      logic [7:0] ones;
      ones = 8'hFF;
      if (p == 0)      return 8'h00;
      else if (p <= N) return ones << (N - p);
      else             return ones >> (p - N);
   endfunction

   // Phase of a word, or -1 if no phase produces it.
   function automatic int decode(input logic [7:0] w);
      for (int p = 0; p < SPAN; p++)
         if (code_of(p) == w) return p;
      return -1;
   endfunction

   // Advance the model by the inputs that the next rising edge will sample.
   task automatic model_step();
      int p;
      if (!rst) begin
         m_mode = 0; m_exp = 0; m_match = 0; m_miss = 0;
         m_phase = 0; m_pvld = 0; m_locked = 0; m_err = 0;
         m_cnt_a = 0; m_cnt_b = 0;
         model_live = 1;
      end else begin
         m_pvld = 0;
         m_err  = 0;
         if (code_vld) begin
            p = decode(code_in);
            if (p >= 0) begin
               m_phase = p;
               m_pvld  = 1;
            end
            if (m_mode == 0) begin
               if (p >= 0) begin
                  m_exp = (p + 1) % SPAN; m_match = 1; m_mode = 1;
               end
            end else if (m_mode == 1) begin
               if (p < 0) m_mode = 0;
               else if (p == m_exp) begin
                  m_match++;
                  m_exp = (m_exp + 1) % SPAN;
                  if (m_match >= 4) begin m_mode = 2; m_miss = 0; end
               end else begin
                  m_match = 1; m_exp = (p + 1) % SPAN;
               end
            end else begin
               if (p == m_exp) m_miss = 0;
               else begin
                  m_err = 1;
                  if (m_cnt_a < 65535) m_cnt_a++;
                  if (m_cnt_b < 3)     m_cnt_b++;
                  m_miss++;
                  if (m_miss >= 2) m_mode = 0;
               end
               m_exp = (m_exp + 1) % SPAN;
            end
            m_locked = (m_mode == 2) ? 1 : 0;
         end
      end
   endtask

   // Compare on the falling edge, then step the model for the next edge.
   always @(negedge clk) begin
      if (model_live) begin
         check("cyc_phase_a",  int'(phase_a),   m_phase);
         check("cyc_pvld_a",   int'(pvld_a),    m_pvld);
         check("cyc_locked_a", int'(locked_a),  m_locked);
         check("cyc_err_a",    int'(err_a),     m_err);
         check("cyc_errcnt_a", int'(err_cnt_a), m_cnt_a);
         check("cyc_phase_b",  int'(phase_b),   m_phase);
         check("cyc_locked_b", int'(locked_b),  m_locked);
         check("cyc_err_b",    int'(err_b),     m_err);
         check("cyc_errcnt_b", int'(err_cnt_b), m_cnt_b);
      end
      model_step();
   end

   task automatic send(input logic [7:0] w);
      code_in  = w;
      code_vld = 1'b1;
      @(posedge clk); #1;
      code_vld = 1'b0;
   endtask

   task automatic send_ph(input int p);
      send(code_of(p));
      tx_p = (p + 1) % SPAN;
   endtask

   // Corrupted word in place of the next phase; the transmitter moves on.
   task automatic send_bad(input logic [7:0] w);
      send(w);
      tx_p = (tx_p + 1) % SPAN;
   endtask

   task automatic idle(input int n);
      code_vld = 1'b0;
      code_in  = 8'h5A;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst      = 1'b0;
      code_vld = 1'b1;
      code_in  = code_of(12);
      @(posedge clk); #1;
      rst      = 1'b1;
      code_vld = 1'b0;
   endtask

   initial begin
      rst      = 1'b0;
      code_vld = 1'b0;
      code_in  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_phase",  int'(phase_a),   0);
      check("rst_pvld",   int'(pvld_a),    0);
      check("rst_locked", int'(locked_a),  0);
      check("rst_err",    int'(err_a),     0);
      check("rst_errcnt", int'(err_cnt_a), 0);
      rst = 1'b1;

      // Pin the model's mapping to hand-computed values.
      check("map_p15", int'(code_of(15)), 8'h01);
      check("map_p2",  int'(code_of(2)),  8'hC0);
      check("map_p8",  int'(code_of(8)),  8'hFF);
      check("dec_7f",  decode(8'h7F),     9);
      check("dec_5a",  decode(8'h5A),     -1);

      // 1. Lock from transmitter reset word, then three full wraps.
      idle(2);
      send_ph(15); check("t1_ph15", int'(phase_a), 15); check("t1_lk0", int'(locked_a), 0);
      send_ph(0);  check("t1_ph0",  int'(phase_a), 0);
      send_ph(1);  check("t1_ph1",  int'(phase_a), 1);  check("t1_lk1", int'(locked_a), 0);
      send_ph(2);  check("t1_ph2",  int'(phase_a), 2);  check("t1_lk2", int'(locked_a), 1);
      send_ph(3);  check("t1_ph3",  int'(phase_a), 3);  check("t1_pv3", int'(pvld_a), 1);
      for (int i = 0; i < 3 * SPAN; i++) send_ph(tx_p);
      check("t1_errcnt", int'(err_cnt_a), 0);
      check("t1_locked", int'(locked_a), 1);

      // 2. Single glitch in LOCK, then a second one after a good word.
      send_bad(8'h5A);
      check("t2_err",    int'(err_a),     1);
      check("t2_errcnt", int'(err_cnt_a), 1);
      check("t2_phase",  int'(phase_a),   3);
      check("t2_pvld",   int'(pvld_a),    0);
      check("t2_locked", int'(locked_a),  1);
      send_ph(tx_p);
      check("t2_err_clr", int'(err_a),    0);
      send_bad(8'h5A);
      check("t2_lk_after2", int'(locked_a),  1);
      check("t2_errcnt2",   int'(err_cnt_a), 2);
      send_ph(tx_p);
      check("t2_lk_final", int'(locked_a), 1);

      // 4. code_vld gaps between legal successors.
      send_ph(tx_p);
      for (int i = 0; i < 5; i++) begin
         idle(1);
         check("t4_gap_pvld", int'(pvld_a), 0);
         check("t4_gap_err",  int'(err_a),  0);
      end
      send_ph(tx_p);
      check("t4_phase",  int'(phase_a),  9);
      check("t4_err",    int'(err_a),    0);
      check("t4_locked", int'(locked_a), 1);

      // One more glitch brings err_cnt to 3 while still locked.
      send_bad(8'h5A);
      send_ph(tx_p);
      check("t5_pre_cnt", int'(err_cnt_a), 3);
      check("t5_pre_lk",  int'(locked_a),  1);

      // 5. Reset mid-lock with a legal word presented.
      pulse_reset();
      check("t5_locked", int'(locked_a),  0);
      check("t5_errcnt", int'(err_cnt_a), 0);
      check("t5_phase",  int'(phase_a),   0);
      check("t5_pvld",   int'(pvld_a),    0);
      send_ph(0); send_ph(1); send_ph(2);
      check("t5_hunt_lk0", int'(locked_a), 0);
      send_ph(3);
      check("t5_relock", int'(locked_a), 1);

      // 3. Stalled transmitter: 0xFF repeated twice where 9 and 10 belong.
      while (tx_p != 9) send_ph(tx_p);
      send_bad(8'hFF);
      check("t3_err1",  int'(err_a),     1);
      check("t3_lk1",   int'(locked_a),  1);
      check("t3_pvld1", int'(pvld_a),    1);
      send_bad(8'hFF);
      check("t3_err2",    int'(err_a),     1);
      check("t3_errcnt",  int'(err_cnt_a), 2);
      check("t3_dropped", int'(locked_a),  0);
      check("t3_phase",   int'(phase_a),   8);
      send_ph(tx_p); send_ph(tx_p); send_ph(tx_p);
      check("t3_lk_3", int'(locked_a), 0);
      send_ph(tx_p);
      check("t3_relock", int'(locked_a), 1);

      // 6. Saturation on the 2-bit counter: alternate misses and matches.
      pulse_reset();
      for (int i = 0; i < 4; i++) send_ph(tx_p);
      check("t6_locked", int'(locked_b), 1);
      for (int k = 1; k <= 6; k++) begin
         send_bad(8'h5A);
         check("t6_cnt_b", int'(err_cnt_b), (k < 3) ? k : 3);
         check("t6_cnt_a", int'(err_cnt_a), k);
         check("t6_lk_b",  int'(locked_b),  1);
         send_ph(tx_p);
      end
      check("t6_final_b", int'(err_cnt_b), 3);

      idle(3);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_twist_rx
